fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 135 +++++++++++++
 tb/tb_fetch_queue.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - credit-based instruction fetch unit with an in-order PC FIFO and an instruction queue
// Redirects flush the queue and drop the responses of requests issued before the redirect.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [3:0]  queue_count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [3:0]    in_flight_q, in_flight_d;
  logic [3:0]    drop_q, drop_d;
  logic [3:0]    count_q, count_d;
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW-1:0] pf_rd_q, pf_rd_d, pf_wr_q, pf_wr_d;
  logic [31:0]   qdata_q [DEPTH];
  logic [31:0]   qdata_d [DEPTH];
  logic [31:0]   qpc_q   [DEPTH];
  logic [31:0]   qpc_d   [DEPTH];
  logic [31:0]   pf_q    [DEPTH];
  logic [31:0]   pf_d    [DEPTH];

  logic [4:0] credit_used;
  logic       accept;
  logic       push;
  logic       pop;
  logic       unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign imem_req_addr = fetch_pc_q;
  assign inst_valid    = (count_q != 4'd0);
  assign inst          = qdata_q[head_q];
  assign inst_pc       = qpc_q[head_q];
  assign queue_count   = count_q;

  always_comb begin
    // Every queued entry plus every outstanding request holds a credit, so a response always finds room.
    credit_used    = {1'b0, count_q} + {1'b0, in_flight_q};
    imem_req_valid = !reset && !halt && !redirect_valid && (credit_used < 5'(DEPTH));
    accept         = imem_req_valid && imem_req_ready;
    push           = imem_resp_valid && !redirect_valid && (drop_q == 4'd0);
    pop            = inst_valid && inst_ready && !redirect_valid;

    fetch_pc_d  = fetch_pc_q;
    drop_d      = drop_q;
    head_d      = head_q;
    tail_d      = tail_q;
    pf_rd_d     = pf_rd_q;
    pf_wr_d     = pf_wr_q;
    qdata_d     = qdata_q;
    qpc_d       = qpc_q;
    pf_d        = pf_q;
    in_flight_d = in_flight_q + 4'(accept) - 4'(imem_resp_valid);
    count_d     = count_q + 4'(push) - 4'(pop);

    if (accept) begin
      pf_d[pf_wr_q] = fetch_pc_q;
      pf_wr_d       = pf_wr_q + PTR_ONE;
      fetch_pc_d    = fetch_pc_q + 32'd4;
    end

    // Every response retires its PC FIFO slot, whether it is kept or dropped.
    if (imem_resp_valid) begin
      pf_rd_d = pf_rd_q + PTR_ONE;
      if (!redirect_valid && drop_q != 4'd0) begin
        drop_d = drop_q - 4'd1;
      end
    end

    if (push) begin
      qdata_d[tail_q] = imem_resp_data;
      qpc_d[tail_q]   = pf_q[pf_rd_q];
      tail_d          = tail_q + PTR_ONE;
    end

    if (pop) begin
      head_d = head_q + PTR_ONE;
    end

    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      head_d     = '0;
      tail_d     = '0;
      count_d    = 4'd0;
      drop_d     = in_flight_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q  <= RESET_PC;
      in_flight_q <= 4'd0;
      drop_q      <= 4'd0;
      count_q     <= 4'd0;
      head_q      <= '0;
      tail_q      <= '0;
      pf_rd_q     <= '0;
      pf_wr_q     <= '0;
      qdata_q     <= '{default: '0};
      qpc_q       <= '{default: '0};
      pf_q        <= '{default: '0};
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      in_flight_q <= in_flight_d;
      drop_q      <= drop_d;
      count_q     <= count_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      pf_rd_q     <= pf_rd_d;
      pf_wr_q     <= pf_wr_d;
      qdata_q     <= qdata_d;
      qpc_q       <= qpc_d;
      pf_q        <= pf_d;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue with a 1-cycle memory model and scoreboard
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic [3:0]  queue_count;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .inst_ready      (inst_ready),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .halt            (halt),
    .queue_count     (queue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    bit          ir;
    bit          v;
    logic [31:0] pc;
    logic [3:0]  cnt;
    bit          rv;
    logic [31:0] addr;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  bit          resp_en;
  logic [31:0] model_pc;
  logic [31:0] pend[$];
  bit          stale[$];
  exp_t        exp_q[$];
  logic [31:0] dlv[$];
  vec_t        tbl[19];

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'hC0DE_5A5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
    end
  endtask

  // First half of a cycle: memory drives its response, then wait to the sampling point.
  task automatic cyc_pre();
    imem_resp_valid = resp_en && (pend.size() > 0);
    imem_resp_data  = imem_resp_valid ? mdata(pend[0]) : 32'h0;
    @(negedge clk);
  endtask

  // Second half: scoreboard bookkeeping at the sampling point, then advance past the edge.
  task automatic cyc_post();
    bit acc;
    bit rsp;
    exp_t e;
    acc = imem_req_valid && imem_req_ready;
    rsp = imem_resp_valid;
    chk("req_valid", 32'(imem_req_valid),
        32'(!halt && !redirect_valid && ((exp_q.size() + pend.size()) < DEPTH)));
    chk("inst_valid", 32'(inst_valid), 32'(exp_q.size() != 0));
    chk("queue_count", 32'(queue_count), 32'(exp_q.size()));
    if (acc) begin
      chk("req_addr", imem_req_addr, model_pc);
      model_pc = model_pc + 32'd4;
    end
    if (redirect_valid) begin
      exp_q.delete();
      model_pc = {redirect_pc[31:2], 2'b00};
      foreach (stale[i]) stale[i] = 1'b1;
    end else if (inst_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        chk("pop_when_empty", 32'(1), 32'(0));
      end else begin
        e = exp_q.pop_front();
        chk("inst_pc", inst_pc, e.pc);
        chk("inst", inst, e.data);
        dlv.push_back(inst_pc);
      end
    end
    if (rsp) begin
      if (!redirect_valid && !stale[0]) begin
        e.pc   = pend[0];
        e.data = mdata(pend[0]);
        exp_q.push_back(e);
      end
      void'(pend.pop_front());
      void'(stale.pop_front());
    end
    if (acc) begin
      pend.push_back(imem_req_addr);
      stale.push_back(1'b0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    cyc_pre();
    cyc_post();
  endtask

  task automatic run_until_dlv(input int budget);
    for (int i = 0; i < budget && dlv.size() == 0; i++) cycle();
    if (dlv.size() == 0) chk("dlv_timeout", 32'(0), 32'(1));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset           = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'h0;
    halt            = 1'b0;
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'(0));
    chk("rst_inst_valid", 32'(inst_valid), 32'(0));
    chk("rst_count", 32'(queue_count), 32'(0));
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    pend.delete();
    stale.delete();
    exp_q.delete();
    dlv.delete();
    model_pc = 32'h0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 32'h00, 4'd0, 1'b1, 32'h00};
    tbl[1]  = '{1'b1, 1'b0, 32'h00, 4'd0, 1'b1, 32'h04};
    tbl[2]  = '{1'b1, 1'b1, 32'h00, 4'd1, 1'b1, 32'h08};
    tbl[3]  = '{1'b1, 1'b1, 32'h04, 4'd1, 1'b1, 32'h0C};
    tbl[4]  = '{1'b0, 1'b1, 32'h08, 4'd1, 1'b1, 32'h10};
    tbl[5]  = '{1'b0, 1'b1, 32'h08, 4'd2, 1'b1, 32'h14};
    tbl[6]  = '{1'b0, 1'b1, 32'h08, 4'd3, 1'b0, 32'h00};
    for (int i = 7; i < 14; i++) tbl[i] = '{1'b0, 1'b1, 32'h08, 4'd4, 1'b0, 32'h00};
    tbl[14] = '{1'b1, 1'b1, 32'h08, 4'd4, 1'b0, 32'h00};
    tbl[15] = '{1'b1, 1'b1, 32'h0C, 4'd3, 1'b1, 32'h18};
    tbl[16] = '{1'b1, 1'b1, 32'h10, 4'd2, 1'b1, 32'h1C};
    tbl[17] = '{1'b1, 1'b1, 32'h14, 4'd2, 1'b1, 32'h20};
    tbl[18] = '{1'b1, 1'b1, 32'h18, 4'd2, 1'b1, 32'h24};

    reset           = 1'b1;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    inst_ready      = 1'b1;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'h0;
    halt            = 1'b0;
    resp_en         = 1'b1;

    // Streaming from reset, then a 10-cycle decode stall that saturates the queue.
    do_reset();
    for (int i = 0; i < 19; i++) begin
      inst_ready = tbl[i].ir;
      cyc_pre();
      chk($sformatf("tbl%0d_valid", i), 32'(inst_valid), 32'(tbl[i].v));
      if (tbl[i].v) chk($sformatf("tbl%0d_pc", i), inst_pc, tbl[i].pc);
      chk($sformatf("tbl%0d_count", i), 32'(queue_count), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_rv", i), 32'(imem_req_valid), 32'(tbl[i].rv));
      if (tbl[i].rv) chk($sformatf("tbl%0d_addr", i), imem_req_addr, tbl[i].addr);
      cyc_post();
    end

    // Memory not ready for 5 cycles while the request sits at 0x40.
    do_reset();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    cycle();
    redirect_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc_pre();
      chk("stall_valid", 32'(imem_req_valid), 32'(1));
      chk("stall_addr", imem_req_addr, 32'h40);
      cyc_post();
    end
    imem_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    chk("stall_first", dlv.size() > 0 ? dlv[0] : 32'hFFFF_FFFF, 32'h40);
    chk("stall_second", dlv.size() > 1 ? dlv[1] : 32'hFFFF_FFFF, 32'h44);

    // Redirect with three requests outstanding; their responses must be dropped.
    do_reset();
    inst_ready = 1'b0;
    resp_en    = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    cycle();
    redirect_valid = 1'b0;
    resp_en        = 1'b1;
    inst_ready     = 1'b1;
    cyc_pre();
    chk("redir_addr", imem_req_addr, 32'h100);
    chk("redir_rv", 32'(imem_req_valid), 32'(1));
    cyc_post();
    run_until_dlv(12);
    chk("redir_first_pc", dlv.size() > 0 ? dlv[0] : 32'hFFFF_FFFF, 32'h100);

    // Halt with two requests outstanding: both still delivered, nothing new issued.
    do_reset();
    inst_ready = 1'b0;
    resp_en    = 1'b0;
    for (int i = 0; i < 2; i++) cycle();
    halt       = 1'b1;
    resp_en    = 1'b1;
    inst_ready = 1'b1;
    for (int i = 0; i < 6; i++) cycle();
    chk("halt_count", 32'(queue_count), 32'(0));
    chk("halt_ndlv", 32'(dlv.size()), 32'(2));
    chk("halt_pc0", dlv.size() > 0 ? dlv[0] : 32'hFFFF_FFFF, 32'h0);
    chk("halt_pc1", dlv.size() > 1 ? dlv[1] : 32'hFFFF_FFFF, 32'h4);
    halt = 1'b0;

    // Redirect together with a pop at queue_count 2, plus a response in the redirect cycle.
    do_reset();
    inst_ready = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    cyc_pre();
    chk("rp_count_before", 32'(queue_count), 32'(2));
    cyc_post();
    redirect_valid = 1'b0;
    chk("rp_count_after", 32'(queue_count), 32'(0));
    chk("rp_no_dlv", 32'(dlv.size()), 32'(0));
    run_until_dlv(10);
    chk("rp_first_pc", dlv.size() > 0 ? dlv[0] : 32'hFFFF_FFFF, 32'h200);

    // Back-to-back redirects: the second one wins.
    dlv.delete();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    cycle();
    redirect_pc = 32'h405;
    cycle();
    redirect_valid = 1'b0;
    dlv.delete();
    run_until_dlv(10);
    chk("b2b_first_pc", dlv.size() > 0 ? dlv[0] : 32'hFFFF_FFFF, 32'h404);
    for (int i = 0; i < 4; i++) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
